uart_rx_pkt_ctrl: RTL and testbench

//  Packet controller behind uart_rx: consumes its byte stream (data_out/data_valid),

---
 rtl/uart_rx_pkt_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_rx_pkt_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_pkt_ctrl.sv
// uart_rx_pkt_ctrl: packet framer behind uart_rx.
// Hunts SYNC_BYTE, reads LEN, streams LEN payload bytes into a small FIFO
// drained by a valid/ready consumer, then pulses o_pkt_done with a status word.
// Optional feature macro: UART_PKT_CKSUM_EN adds a trailing checksum byte
// (sum of LEN, payload and checksum must be 0 mod 256) and status bit 3.
module uart_rx_pkt_ctrl #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned MAX_LEN      = 16,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned TIMEOUT_CLKS = 1024
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    input  logic       i_byte_ready,
    output logic       o_pkt_done,
    output logic [3:0] o_pkt_status,
    output logic       o_busy
);

    localparam int unsigned   AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned   CW        = AW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [7:0]    MAX_LEN_C = 8'(MAX_LEN);
    localparam logic [15:0]   TIMEOUT_C = 16'(TIMEOUT_CLKS);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_LEN     = 2'd1,
`ifdef UART_PKT_CKSUM_EN
        ST_CKSUM   = 2'd3,
`endif
        ST_PAYLOAD = 2'd2
    } state_t;

`ifdef UART_PKT_CKSUM_EN
    // A frame is good when the running sum plus the checksum byte wraps to zero.
    function automatic logic cksum_bad(input logic [7:0] sum, input logic [7:0] b);
        logic [7:0] total;
        total = sum + b;
        return (total != 8'h00);
    endfunction

    logic [7:0]    sum_r;
`endif

    state_t        state_r;
    logic [7:0]    remaining_r;
    logic          ovf_r;
    logic [15:0]   timer_r;

    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    logic          push_s;
    logic          pop_s;
    logic          full_s;
    logic          push_ok_s;
    logic          ovf_now_s;
    logic [AW-1:0] rd_nxt_s;
    logic [CW-1:0] count_nxt_s;
    logic [7:0]    head_nxt_s;
    logic [15:0]   timer_nxt_s;
    logic          timeout_s;

    // FIFO control: push/pop qualification and next head value for the registered output.
    always_comb begin
        push_s      = (state_r == ST_PAYLOAD) && i_rx_valid;
        pop_s       = (count_r != {CW{1'b0}}) && i_byte_ready;
        full_s      = (count_r == DEPTH_C);
        push_ok_s   = push_s && (!full_s || pop_s);
        ovf_now_s   = push_s && full_s && !pop_s;
        rd_nxt_s    = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
        count_nxt_s = count_r + {{(CW-1){1'b0}}, push_ok_s} - {{(CW-1){1'b0}}, pop_s};
        // When the FIFO drains to the slot being written this cycle, bypass the incoming byte.
        if (push_ok_s && (rd_nxt_s == wr_ptr_r)) begin
            head_nxt_s = i_rx_data;
        end else begin
            head_nxt_s = mem_r[rd_nxt_s];
        end
    end

    // Inter-byte idle timer: cleared by any strobe or while hunting, saturates at the limit.
    always_comb begin
        if (i_rx_valid || (state_r == ST_HUNT)) begin
            timer_nxt_s = 16'd0;
        end else if (timer_r >= TIMEOUT_C) begin
            timer_nxt_s = TIMEOUT_C;
        end else begin
            timer_nxt_s = timer_r + 16'd1;
        end
        timeout_s = (state_r != ST_HUNT) && !i_rx_valid && (timer_nxt_s == TIMEOUT_C);
    end

    // FIFO storage: payload bytes written at the tail.
    always_ff @(posedge i_clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= i_rx_data;
        end
    end

    // FIFO pointers, occupancy and registered head/valid outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            count_r      <= {CW{1'b0}};
            o_byte_valid <= 1'b0;
            o_byte       <= 8'h00;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            rd_ptr_r     <= rd_nxt_s;
            count_r      <= count_nxt_s;
            o_byte_valid <= (count_nxt_s != {CW{1'b0}});
            if (count_nxt_s != {CW{1'b0}}) begin
                o_byte <= head_nxt_s;
            end
        end
    end

    // Frame FSM with registered done pulse, status and busy flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r      <= ST_HUNT;
            remaining_r  <= 8'h00;
            ovf_r        <= 1'b0;
            timer_r      <= 16'd0;
            o_pkt_done   <= 1'b0;
            o_pkt_status <= 4'h0;
            o_busy       <= 1'b0;
`ifdef UART_PKT_CKSUM_EN
            sum_r        <= 8'h00;
`endif
        end else begin
            timer_r    <= timer_nxt_s;
            o_pkt_done <= 1'b0;
            case (state_r)
                ST_HUNT: begin
                    if (i_rx_valid && (i_rx_data == SYNC_BYTE)) begin
                        state_r <= ST_LEN;
                        ovf_r   <= 1'b0;
                        o_busy  <= 1'b1;
                    end
                end
                ST_LEN: begin
                    if (i_rx_valid) begin
                        if ((i_rx_data == 8'h00) || (i_rx_data > MAX_LEN_C)) begin
                            o_pkt_done   <= 1'b1;
                            o_pkt_status <= 4'b0001;
                            state_r      <= ST_HUNT;
                            o_busy       <= 1'b0;
                        end else begin
                            remaining_r <= i_rx_data;
`ifdef UART_PKT_CKSUM_EN
                            sum_r       <= i_rx_data;
`endif
                            state_r     <= ST_PAYLOAD;
                        end
                    end else if (timeout_s) begin
                        o_pkt_done   <= 1'b1;
                        o_pkt_status <= {1'b0, ovf_r, 1'b1, 1'b0};
                        state_r      <= ST_HUNT;
                        o_busy       <= 1'b0;
                    end
                end
                ST_PAYLOAD: begin
                    if (i_rx_valid) begin
                        remaining_r <= remaining_r - 8'd1;
                        if (ovf_now_s) begin
                            ovf_r <= 1'b1;
                        end
`ifdef UART_PKT_CKSUM_EN
                        sum_r <= sum_r + i_rx_data;
                        if (remaining_r == 8'd1) begin
                            state_r <= ST_CKSUM;
                        end
`else
                        if (remaining_r == 8'd1) begin
                            o_pkt_done   <= 1'b1;
                            o_pkt_status <= {1'b0, (ovf_r | ovf_now_s), 2'b00};
                            state_r      <= ST_HUNT;
                            o_busy       <= 1'b0;
                        end
`endif
                    end else if (timeout_s) begin
                        o_pkt_done   <= 1'b1;
                        o_pkt_status <= {1'b0, ovf_r, 1'b1, 1'b0};
                        state_r      <= ST_HUNT;
                        o_busy       <= 1'b0;
                    end
                end
`ifdef UART_PKT_CKSUM_EN
                ST_CKSUM: begin
                    if (i_rx_valid) begin
                        o_pkt_done   <= 1'b1;
                        o_pkt_status <= {cksum_bad(sum_r, i_rx_data), ovf_r, 2'b00};
                        state_r      <= ST_HUNT;
                        o_busy       <= 1'b0;
                    end else if (timeout_s) begin
                        o_pkt_done   <= 1'b1;
                        o_pkt_status <= {1'b0, ovf_r, 1'b1, 1'b0};
                        state_r      <= ST_HUNT;
                        o_busy       <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_r <= ST_HUNT;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Self-checking bench for uart_rx_pkt_ctrl: table of frames plus hand-written
// overflow, reset and timeout sequences; payload checked through a scoreboard queue.
module tb_uart_rx_pkt_ctrl;

`ifdef UART_PKT_CKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] o_byte;
    logic       o_byte_valid;
    logic       byte_ready;
    logic       o_pkt_done;
    logic [3:0] o_pkt_status;
    logic       o_busy;

    int         checks = 0;
    int         failures = 0;
    int         done_cnt = 0;
    int         pop_cnt = 0;
    logic [3:0] last_status = 4'h0;
    logic [7:0] exp_q[$];

    typedef struct packed {
        logic       pre_en;
        logic [7:0] pre;
        logic [7:0] len;
        logic [7:0] p0;
        logic [7:0] step;
        logic [4:0] npay;
        logic       ck_bad;
        logic [3:0] exp_status;
    } vec_t;

    vec_t vt [9];

    always #5 clk = ~clk;

    uart_rx_pkt_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_byte       (o_byte),
        .o_byte_valid (o_byte_valid),
        .i_byte_ready (byte_ready),
        .o_pkt_done   (o_pkt_done),
        .o_pkt_status (o_pkt_status),
        .o_busy       (o_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Consumer side: count done pulses and compare every popped byte with the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_pkt_done) begin
                done_cnt++;
                last_status = o_pkt_status;
            end
            if (o_byte_valid && byte_ready) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    check("byte_without_expectation", {24'd0, o_byte}, 32'hFFFF_FFFF);
                end else begin
                    check("o_byte", {24'd0, o_byte}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        int         d0;
        logic [7:0] sum;
        logic [7:0] b;
        logic [3:0] exp;
        if (v.pre_en) send(v.pre);
        check($sformatf("v%0d_idle_before_sync", idx), {31'd0, o_busy}, 32'd0);
        d0 = done_cnt;
        send(SYNC);
        check($sformatf("v%0d_busy_in_frame", idx), {31'd0, o_busy}, 32'd1);
        send(v.len);
        sum = v.len;
        for (int i = 0; i < int'(v.npay); i++) begin
            b = v.p0 + 8'(i) * v.step;
            sum += b;
            exp_q.push_back(b);
            send(b);
        end
        if (CK_EN && (v.npay != 5'd0)) send(8'h00 - sum + {7'd0, v.ck_bad});
        exp = CK_EN ? v.exp_status : (v.exp_status & 4'h7);
        check($sformatf("v%0d_done_timing", idx), {31'd0, o_pkt_done}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check($sformatf("v%0d_done_count", idx), done_cnt - d0, 32'd1);
        check($sformatf("v%0d_status", idx), {28'd0, last_status}, {28'd0, exp});
        check($sformatf("v%0d_status_held", idx), {28'd0, o_pkt_status}, {28'd0, exp});
        check($sformatf("v%0d_busy_after", idx), {31'd0, o_busy}, 32'd0);
        check($sformatf("v%0d_fifo_empty", idx), {31'd0, o_byte_valid}, 32'd0);
    endtask

    initial begin
        int         d0;
        int         p0;
        int         found;
        logic [7:0] sum;
        logic [7:0] b;

        //            pre_en pre    len    p0     step   npay  ckbad status
        vt[0] = '{1'b1, 8'h00, 8'h03, 8'h11, 8'h11, 5'd3,  1'b0, 4'h0};
        vt[1] = '{1'b0, 8'h00, 8'h02, 8'h10, 8'h10, 5'd2,  1'b1, 4'h8};
        vt[2] = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 5'd0,  1'b0, 4'h1};
        vt[3] = '{1'b0, 8'h00, 8'h14, 8'h00, 8'h00, 5'd0,  1'b0, 4'h1};
        vt[4] = '{1'b0, 8'h00, 8'h11, 8'h00, 8'h00, 5'd0,  1'b0, 4'h1};
        vt[5] = '{1'b1, 8'h3C, 8'h10, 8'hA0, 8'h01, 5'd16, 1'b0, 4'h0};
        vt[6] = '{1'b0, 8'h00, 8'h01, 8'hA5, 8'h00, 5'd1,  1'b0, 4'h0};
        vt[7] = '{1'b0, 8'h00, 8'h05, 8'hFF, 8'h13, 5'd5,  1'b1, 4'h8};
        vt[8] = '{1'b0, 8'h00, 8'hFF, 8'h00, 8'h00, 5'd0,  1'b0, 4'h1};

        rst        = 1'b1;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        byte_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_byte_valid", {31'd0, o_byte_valid}, 32'd0);
        check("rst_byte", {24'd0, o_byte}, 32'd0);
        check("rst_done", {31'd0, o_pkt_done}, 32'd0);
        check("rst_status", {28'd0, o_pkt_status}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) apply_vec(i, vt[i]);

        // Overflow: consumer stalled, 10 payload bytes into an 8-deep FIFO.
        byte_ready = 1'b0;
        d0 = done_cnt;
        send(SYNC);
        send(8'h0A);
        sum = 8'h0A;
        for (int i = 0; i < 10; i++) begin
            b = 8'h40 + 8'(i);
            sum += b;
            if (i < 8) exp_q.push_back(b);
            send(b);
        end
        if (CK_EN) send(8'h00 - sum);
        check("ovf_done_timing", {31'd0, o_pkt_done}, 32'd1);
        check("ovf_status", {28'd0, o_pkt_status}, 32'h4);
        repeat (2) @(posedge clk);
        #1;
        check("ovf_done_count", done_cnt - d0, 32'd1);
        check("ovf_head_valid", {31'd0, o_byte_valid}, 32'd1);
        check("ovf_head_byte", {24'd0, o_byte}, 32'h40);
        p0 = pop_cnt;
        byte_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("ovf_drain_count", pop_cnt - p0, 32'd8);
        check("ovf_drained_valid", {31'd0, o_byte_valid}, 32'd0);
        check("ovf_queue_empty", exp_q.size(), 32'd0);

        // Reset mid-payload with three bytes held in the FIFO.
        byte_ready = 1'b0;
        send(SYNC);
        send(8'h08);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        check("mid_fifo_valid", {31'd0, o_byte_valid}, 32'd1);
        check("mid_busy", {31'd0, o_busy}, 32'd1);
        d0 = done_cnt;
        p0 = pop_cnt;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("srst_byte_valid", {31'd0, o_byte_valid}, 32'd0);
        check("srst_byte", {24'd0, o_byte}, 32'd0);
        check("srst_status", {28'd0, o_pkt_status}, 32'd0);
        check("srst_done", {31'd0, o_pkt_done}, 32'd0);
        check("srst_busy", {31'd0, o_busy}, 32'd0);
        byte_ready = 1'b1;
        send(8'h05);
        repeat (3) @(posedge clk);
        #1;
        check("srst_still_hunting", {31'd0, o_busy}, 32'd0);
        check("srst_no_done", done_cnt - d0, 32'd0);
        check("srst_no_pops", pop_cnt - p0, 32'd0);

        // Timeout after one payload byte, then a normal frame.
        exp_q.push_back(8'h01);
        send(SYNC);
        send(8'h04);
        send(8'h01);
        found = 0;
        for (int k = 1; k <= 1100; k++) begin
            @(posedge clk);
            #1;
            if (o_pkt_done) begin
                found = k;
                break;
            end
        end
        check("timeout_cycle", found, 32'd1024);
        check("timeout_status", {28'd0, o_pkt_status}, 32'h2);
        check("timeout_busy", {31'd0, o_busy}, 32'd0);
        apply_vec(9, vt[0]);

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
